// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU slice.
//   - opcode encodings for the c input of alu_pipe
//   - bit positions of the {N,Z,C,V} flags vector
//   - state encoding for the sequential multiplier FSM
// The multiplier (and OP_MUL) only take effect in builds that define ALU_MUL_EN.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  // OP_MUL shares its encoding with OP_SLT; which one applies depends on the build.
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FL_N = 3;
  localparam int FL_Z = 2;
  localparam int FL_C = 1;
  localparam int FL_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
// Instantiated by alu_pipe only in builds that define ALU_MUL_EN.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     begin a multiply of a*b (only honoured in IDLE)
//   a, b      WIDTH-bit unsigned operands
//   done      high for the single DONE cycle after the last iteration
//   product   full 2*WIDTH-bit product; stays stable until the next start
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);

  mul_state_e         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               done_q, done_d;

  // Each RUN cycle adds the shifted multiplicand when the current multiplier
  // LSB is set; WIDTH iterations (cnt 0..WIDTH-1) cover every multiplier bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshakes and NZCV flags.
// Optional feature: define ALU_MUL_EN to turn opcode 111 into a multi-cycle
// unsigned MUL (low WIDTH bits of the product); otherwise 111 is signed SLT.
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid / in_ready  operation handshake (src_a, src_b, c)
//   src_a, src_b         WIDTH-bit operands
//   c                    3-bit opcode (see alu_pkg)
//   out_valid/out_ready  result handshake (data_out, flags)
//   data_out             WIDTH-bit result
//   flags                {N,Z,C,V}
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             busy;
  logic             accept;
  logic             can_load;
  logic             load_alu;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  // The output register may take a new result when empty or being drained.
  assign can_load = !out_valid_q || out_ready;
  assign in_ready = !busy && can_load;
  assign accept   = in_valid && in_ready;

  assign add_full = {1'b0, src_a} + {1'b0, src_b};
  assign sub_res  = src_a - src_b;
  assign shamt    = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (c)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (src_a[MSB] == src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_c   = src_a < src_b;
        alu_v   = (src_a[MSB] != src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_SLL: alu_res = src_a << shamt;
      OP_SRL: alu_res = src_a >> shamt;
`ifdef ALU_MUL_EN
      default: alu_res = '0;
`else
      default: alu_res = WIDTH'($signed(src_a) < $signed(src_b));
`endif
    endcase
  end

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               load_mul;
  logic               busy_q, busy_d;
  logic               mul_wait_q, mul_wait_d;

  assign mul_start = accept && (c == OP_MUL);
  assign load_alu  = accept && (c != OP_MUL);
  // A finished product that cannot load yet is parked until the consumer drains.
  assign load_mul  = (mul_done || mul_wait_q) && can_load;
  assign busy      = busy_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    busy_d     = busy_q;
    mul_wait_d = (mul_done || mul_wait_q) && !can_load;
    if (mul_start) begin
      busy_d = 1'b1;
    end
    if (load_mul) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      mul_wait_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      mul_wait_q <= mul_wait_d;
    end
  end
`else
  assign busy     = 1'b0;
  assign load_alu = accept;
`endif

  // A load at the same edge as a drain keeps out_valid high with new data.
  always_comb begin
    data_d      = data_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (load_alu) begin
      data_d         = alu_res;
      flags_d[FL_N]  = alu_res[MSB];
      flags_d[FL_Z]  = (alu_res == '0);
      flags_d[FL_C]  = alu_c;
      flags_d[FL_V]  = alu_v;
      out_valid_d    = 1'b1;
    end
`ifdef ALU_MUL_EN
    if (load_mul) begin
      data_d         = mul_product[WIDTH-1:0];
      flags_d[FL_N]  = mul_product[MSB];
      flags_d[FL_Z]  = (mul_product[WIDTH-1:0] == '0);
      flags_d[FL_C]  = |mul_product[2*WIDTH-1:WIDTH];
      flags_d[FL_V]  = 1'b0;
      out_valid_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule
